// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes Rx, qualifies the start bit, samples 8N1 frames at mid-bit
// and presents bytes on a valid/ready handshake. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_ctrl #(
    parameter int unsigned CLK_DIV = 325,
    parameter int unsigned OVS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BT_W  = $clog2(OVS);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BT_W-1:0]  BT_HALF = BT_W'(OVS / 2 - 1);
    localparam logic [BT_W-1:0]  BT_MAX  = BT_W'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BT_W-1:0]  bt_q, bt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             tick_c, fall_c, hs_c, load_c;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    assign tick_c = (div_q == DIV_MAX);
    assign fall_c = rx_prev_q & ~rx_sync_q;
    assign hs_c   = valid_q & ready;

    // Two-flop synchronizer plus edge register; idle line level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Oversample divider, re-phased to the start edge when leaving IDLE
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_c || (state_q == IDLE && state_d != IDLE)) begin
            div_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        bt_d        = bt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        load_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (tick_c) begin
            bt_d = (bt_q == BT_MAX) ? '0 : bt_q + BT_W'(1);
        end

        case (state_q)
            IDLE: begin
                bt_d = '0;
                if (fall_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick_c && bt_q == BT_HALF) begin
                    if (!rx_sync_q) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                        bt_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick_c && bt_q == BT_MAX) begin
                    sh_d[idx_q] = rx_sync_q;
                    idx_d       = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_c && bt_q == BT_MAX) begin
                    par_bad_d    = ^{sh_q, rx_sync_q};
                    parity_err_d = par_bad_d;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (tick_c && bt_q == BT_MAX) begin
                    if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                        load_c = ~par_bad_q;
`else
                        load_c = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake clears first so a same-cycle load or overrun set wins
        if (hs_c) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (load_c) begin
            if (!valid_q || hs_c) begin
                data_d  = sh_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bt_q        <= '0;
            idx_q       <= 3'd0;
            sh_q        <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bt_q        <= bt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLK_DIV=4, OVS=16 (64 clk per bit) with a byte scoreboard.
module tb_uart_rx_ctrl;

    localparam int unsigned BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MIN = 664;
    localparam int LAT_MAX = 724;
`else
    localparam int LAT_MIN = 600;
    localparam int LAT_MAX = 660;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         pe_cnt = 0;
`endif

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         valid_rise = 0;
    int         valid_cnt = 0;
    int         fe_cnt = 0;
    int         v0, f0, lat;
    logic       valid_prev = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    uart_rx_ctrl #(.CLK_DIV(4), .OVS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rx        (Rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_cnt++;
            if (valid && !valid_prev) valid_rise = cyc;
            if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (valid && ready) begin
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check("rx_byte", 32'(data), 32'(exp_b));
                end
            end
        end
        valid_prev = valid & rst_n;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        Rx = v;
        wait_clk(BIT_CLK);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic p, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(stop_bit);
    endtask
`endif

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
        send_frame_par(b, ^b, stop_bit);
`else
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
`endif
    endtask

    initial begin
        // Reset state
        wait_clk(4);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clk(10);

        // Good frame 0xA5 with ready high
        ready = 1'b1;
        v0 = valid_cnt; f0 = fe_cnt;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clk(BIT_CLK);
        lat = valid_rise - start_cyc;
        check("a5_valid_cycles", 32'(valid_cnt - v0), 32'd1);
        check("a5_latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
        check("a5_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("a5_overrun", 32'(overrun), 32'd0);
        check("a5_busy_idle", 32'(busy), 32'd0);

        // 20-clk glitch rejected at the start sample
        v0 = valid_cnt; f0 = fe_cnt;
        Rx = 1'b0;
        wait_clk(10);
        check("glitch_busy_high", 32'(busy), 32'd1);
        wait_clk(10);
        Rx = 1'b1;
        wait_clk(60);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt - f0), 32'd0);

        // Framing error then line held low (BREAK)
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        wait_clk(100);
        check("fe_pulse_count", 32'(fe_cnt - f0), 32'd1);
        check("fe_valid", 32'(valid_cnt - v0), 32'd0);
        check("fe_busy_break", 32'(busy), 32'd1);
        Rx = 1'b1;
        wait_clk(10);
        check("fe_busy_released", 32'(busy), 32'd0);

        // Overrun: second byte dropped while first is unconsumed
        ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(10);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_data_held", 32'(data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        ready = 1'b1;
        wait_clk(1);
        ready = 1'b0;
        wait_clk(2);
        check("ovr_valid_cleared", 32'(valid), 32'd0);
        check("ovr_flag_cleared", 32'(overrun), 32'd0);

        // Reset mid-frame, then a fresh byte
        ready = 1'b1;
        v0 = valid_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_clk(BIT_CLK / 2);
        check("mid_frame_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_data", 32'(data), 32'h00);
        check("rstmid_valid", 32'(valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_overrun", 32'(overrun), 32'd0);
        Rx = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(100);
        check("post_rst_no_byte", 32'(valid_cnt - v0), 32'd0);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clk(BIT_CLK);
        check("post_rst_one_byte", 32'(valid_cnt - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Parity: bad parity drops the byte, good parity delivers it
        v0 = valid_cnt; f0 = pe_cnt;
        send_frame_par(8'h07, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("par_bad_pulse", 32'(pe_cnt - f0), 32'd1);
        check("par_bad_valid", 32'(valid_cnt - v0), 32'd0);
        f0 = pe_cnt;
        sb.push_back(8'h07);
        send_frame_par(8'h07, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("par_good_pulse", 32'(pe_cnt - f0), 32'd0);
        check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive controller for the serial input path. It oversamples the asynchronous `Rx` line, detects and qualifies the start bit, and samples eight data bits LSB-first at mid-bit. It checks the stop bit and presents each completed byte on a valid/ready handshake to the downstream consumer. It replaces the free-running divider-plus-flag receive scheme with a phase-aligned, framed sequencer.

## Interface
- `CLK_DIV`, default 325: `clk` cycles per oversample tick (50 MHz / (9600 × 16) ≈ 325).
- `OVS`, default 16: oversample ticks per bit. Must be an even number, ≥ 4.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous assert, active-low. One clock domain only.
- `Rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `data`  output  8  received byte, `data[0]` = first data bit on the line.
- `valid`  output  1  `data` holds an unconsumed byte.
- `ready`  input  1  consumer accepts the byte when `valid && ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  sticky flag: a byte was dropped because `valid` was still high.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer, then a 1-flop edge register. All decisions use the synchronized value `rxs`.
- Tick generator: counter 0..CLK_DIV-1. `tick` is asserted when the counter reaches CLK_DIV-1. The counter is forced to 0 when the FSM leaves IDLE, so the tick phase aligns to the start edge.
- Bit-tick counter `bt`: 0..OVS-1, advanced on `tick`.
- FSM states:
  - IDLE: on a falling edge of `rxs`, go to START and clear `bt`.
  - START: when `bt` reaches OVS/2-1 on a tick, sample `rxs`. If low, go to DATA with bit index 0 and clear `bt`. If high, treat it as a glitch and return to IDLE with no outputs.
  - DATA: on each tick where `bt` == OVS-1, shift `rxs` into bit[index] and increment index. After index 7 is sampled, go to STOP.
  - STOP: on a tick where `bt` == OVS-1, sample `rxs`.
    - If the sample is 1, load the byte. If `valid` is low, or a handshake occurs in the same cycle, write `data` and set `valid`. Otherwise drop the byte and set `overrun`.
    - If the sample is 0, pulse `frame_err`, discard the byte, and go to BREAK.
    - Go to IDLE on a good stop bit.
  - BREAK: wait for `rxs` == 1, then go to IDLE.
- `valid` clears on the `valid && ready` cycle unless a new byte loads in that same cycle, in which case it stays high with the new data.
- `overrun` clears on the next `valid && ready` handshake. If the same cycle also sets it, set wins.
- Reset mid-frame: every state and output returns to its reset value immediately. The partial byte is lost, and the FSM waits for a fresh falling edge.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, both counters 0, synchronizer flops 1.
- Detection latency: 3 `clk` cycles from the `Rx` fall to START (2 synchronizer flops plus the edge register).
- Start sample: about OVS/2 ticks after the detected edge. Data samples follow at OVS-tick spacing, at mid-bit.
- `valid` rises 1 `clk` cycle after the stop-bit sampling tick. `frame_err` is high for exactly that one cycle.
- Frame length: about 10 × OVS × CLK_DIV `clk` cycles (≈ 52 000 at the defaults).
- A line held low forever produces exactly one `frame_err`, then stays in BREAK.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: a PARITY state is inserted between DATA and STOP. It samples a 9th bit, checked for even parity over data plus parity. The frame is 11 bits. A mismatch drops the byte and pulses the output `parity_err` for one cycle, and the FSM still checks the stop bit.
  - Undefined: no PARITY state and no `parity_err` port. The frame is 10 bits.

## Test plan
- Use CLK_DIV=4, OVS=16 (64 clk per bit) for all scenarios.
- Send 0xA5 (8N1) with `ready`=1 → `data`=0xA5, and `valid` high for exactly 1 cycle, about 640 clk after the start edge. `frame_err`=0, `overrun`=0.
- Apply a 20-clk low glitch on idle `Rx` → FSM returns to IDLE, and `valid`, `frame_err` and `busy` all return to 0 after the START sample.
- Send 0x3C with the stop bit forced to 0 → one-cycle `frame_err`, `valid` stays 0, `busy` stays high until `Rx` returns to 1.
- With `ready`=0, send 0x11 then 0x22 → `data` stays 0x11 and `overrun`=1. Then assert `ready` for one cycle → `valid` and `overrun` both drop to 0.
- Assert `rst_n`=0 midway through bit 4 of 0xFF, release it, then send 0x5A → outputs read 0 during reset. After release the first byte reported is 0x5A.
- With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 0 → `parity_err` pulses and `valid` stays 0. Send 0x07 with parity bit 1 → `data`=0x07.
